// File: rtl/cbus_axi_bridge.sv
// CBus-to-AXI4 bridge: turns the arbiter's single CBus transaction stream
// into AXI4 INCR read/write bursts, one transaction at a time.

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic        okay;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_axi_bridge
    import cbus_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  cbus_req_t   creq,
    output cbus_resp_t  cresp,
    output logic [3:0]  arid,
    output logic [63:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [63:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_last;

    // The beat counter alone decides the last beat; rlast is deliberately ignored.
    logic unused_rlast;
    assign unused_rlast = rlast;

    assign is_last = (cnt_q == creq.len);

    // The arbiter holds creq stable for the whole transaction, so the AXI
    // payload is a straight combinational copy of the request.
    assign arid    = AXI_ID;
    assign araddr  = creq.addr;
    assign arlen   = {4'b0, creq.len};
    assign arsize  = creq.size;
    assign arburst = 2'b01;
    assign awid    = AXI_ID;
    assign awaddr  = creq.addr;
    assign awlen   = {4'b0, creq.len};
    assign awsize  = creq.size;
    assign awburst = 2'b01;
    assign wdata   = creq.data;
    assign wstrb   = creq.strobe;

    // State and beat counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus handshake outputs and zero-latency CBus responses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        cresp   = '0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (creq.valid) begin
                        state_d = creq.is_write ? WADDR : RADDR;
                        cnt_d   = 4'd0;
                    end
                end
                RADDR: begin
                    arvalid = 1'b1;
                    if (arready) state_d = RDATA;
                end
                RDATA: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        cresp.ready = 1'b1;
                        cresp.data  = rdata;
                        cresp.okay  = (rresp == 2'b00);
                        cresp.last  = is_last;
                        cnt_d       = cnt_q + 4'd1;
                        if (is_last) state_d = IDLE;
                    end
                end
                WADDR: begin
                    awvalid = 1'b1;
                    if (awready) state_d = WDATA;
                end
                WDATA: begin
                    wvalid = 1'b1;
                    wlast  = is_last;
                    if (wready) begin
                        if (is_last) begin
                            state_d = WRESP;
                        end else begin
                            cresp.ready = 1'b1;
                            cresp.okay  = 1'b1;
                            cnt_d       = cnt_q + 4'd1;
                        end
                    end
                end
                WRESP: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        cresp.ready = 1'b1;
                        cresp.last  = 1'b1;
                        cresp.okay  = (bresp == 2'b00);
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
